// File: rtl/dequantize_unit.sv
// Streaming int8 -> Q16.16 dequantizer: out = (q - zero_point) * scale, with a credit-limited output FIFO.
// Define DEQUANT_SATURATE_EN to clamp results to the 32-bit range instead of wrapping.
`timescale 1ns/1ps
module dequantize_unit #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] scale,
  input  logic signed [7:0]  zero_point,
  input  logic [31:0]        size,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_data,
  output logic [31:0]        count,
  output logic               done,
  output logic               ready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic signed [31:0] scale_r;
  logic signed [7:0]  zp_r;
  logic [31:0]        size_r;
  logic [31:0]        accepted;

  logic               vld_p1, vld_p2;
  logic signed [8:0]  d_p1;
  logic signed [31:0] p_p2;
  logic signed [40:0] prod;

  logic signed [31:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        fifo_count;
  logic [AW+1:0]      used;

  logic accept, pop, push, start_acc;

  function automatic logic signed [31:0] clamp_q16(input logic signed [40:0] v);
`ifdef DEQUANT_SATURATE_EN
    if (v > 41'sd2147483647) return 32'sh7FFF_FFFF;
    if (v < -41'sd2147483648) return 32'sh8000_0000;
`endif
    return v[31:0];
  endfunction

  assign start_acc = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = vld_p2;
  // Every sample in flight has a FIFO slot reserved, so a push can never find the FIFO full.
  assign used      = (AW+2)'(fifo_count) + (AW+2)'(vld_p1) + (AW+2)'(vld_p2);
  assign prod      = 41'(d_p1) * 41'(scale_r);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (size == 32'd0) ? DONE : RUN;
      RUN:   if (accept && (accepted + 32'd1 == size_r)) state_nxt = DRAIN;
      DRAIN: if ((count == size_r) || (pop && (count + 32'd1 == size_r))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == IDLE);
    done     = (state == DONE);
    in_ready = (state == RUN) && (accepted < size_r) && (used < (AW+2)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accepted   <= '0;
      count      <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (start_acc) begin
        accepted <= '0;
        count    <= '0;
      end else begin
        if (accept) accepted <= accepted + 32'd1;
        if (pop)    count    <= count + 32'd1;
      end
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Stage 1: zero-point removal; stage 2: scale multiply; then FIFO write.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      scale_r <= scale;
      zp_r    <= zero_point;
      size_r  <= size;
    end
    d_p1 <= 9'(in_data) - 9'(zp_r);
    p_p2 <= clamp_q16(prod);
    if (push) mem[wr_ptr] <= p_p2;
  end

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 32'sd0;

endmodule

// File: tb/tb_dequantize_unit.sv
// Randomized self-checking bench for dequantize_unit against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_dequantize_unit;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n, start, in_valid, in_ready, out_valid, out_ready, done, ready;
  logic signed [31:0] scale;
  logic signed [7:0]  zero_point, in_data;
  logic [31:0]        size, count;
  logic signed [31:0] out_data;

  int n_chk = 0, n_fail = 0;
  logic [31:0] m_scale, m_size;
  int m_zp;
  logic signed [7:0] in_q[$];
  logic [31:0] exp_q[$], got_q[$];
  int acc_cnt, pop_cnt, done_cnt, cyc;

  always #5 clk = ~clk;

  dequantize_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .zero_point(zero_point),
    .size(size), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .done(done), .ready(ready)
  );

  initial begin
    #600000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(input logic signed [7:0] q);
    longint p;
    p = (longint'(q) - longint'(m_zp)) * longint'($signed(m_scale));
`ifdef DEQUANT_SATURATE_EN
    if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
    return p[31:0];
  endfunction

  task automatic start_run(input logic [31:0] sc, input logic signed [7:0] zp, input logic [31:0] n);
    @(negedge clk);
    scale = sc; zero_point = zp; size = n; start = 1'b1;
    m_scale = sc; m_zp = zp; m_size = n;
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic stream(input int vp, input int rp, input int max_cyc, input int stop_acc);
    logic last_pop_prev = 1'b0, stall_prev = 1'b0;
    logic [31:0] data_prev = '0;
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      start = 1'b0;
      scale = $urandom; zero_point = 8'($urandom); size = $urandom;
      in_valid = (in_q.size() > 0) && (int'($urandom_range(99)) < vp);
      if (in_valid) in_data = in_q[0];
      else          in_data = 8'($urandom);
      out_ready = int'($urandom_range(99)) < rp;
      #1;
      n_chk++;
      if (done !== last_pop_prev) begin
        n_fail++; $display("FAIL done_timing: cycle %0d done=%b expected %b", cyc, done, last_pop_prev);
      end
      n_chk++;
      if (ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_ready: cycle %0d ready=%b expected 0", cyc, ready);
      end
      if (done) begin
        done_cnt++;
        break;
      end
      if (stall_prev) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== data_prev) begin
          n_fail++; $display("FAIL hold: out_valid=%b out_data=%h expected 1/%h", out_valid, out_data, data_prev);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_q.pop_front()));
        acc_cnt++;
      end
      last_pop_prev = 1'b0;
      if (out_valid && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL spurious_out: got %h with no pending sample", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            n_fail++; $display("FAIL out_data: got %h expected %h", out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got_q.push_back(out_data);
        pop_cnt++;
        last_pop_prev = (pop_cnt == int'(m_size));
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      cyc++;
      if (acc_cnt >= stop_acc) break;
    end
  endtask

  task automatic finish_run(input string name);
    n_chk++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt); end
    n_chk++;
    if (count !== m_size) begin n_fail++; $display("FAIL %s count: got %0d expected %0d", name, count, m_size); end
    n_chk++;
    if (acc_cnt != int'(m_size)) begin n_fail++; $display("FAIL %s accepted: got %0d expected %0d", name, acc_cnt, m_size); end
    in_valid = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || ready !== 1'b1 || count !== m_size) begin
      n_fail++; $display("FAIL %s after_done: done=%b ready=%b count=%0d expected 0/1/%0d", name, done, ready, count, m_size);
    end
  endtask

  task automatic check_got(input string name, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input int n);
    logic [31:0] ev [3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    n_chk++;
    if (got_q.size() != n) begin
      n_fail++; $display("FAIL %s n_results: got %0d expected %0d", name, got_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_chk++;
        if (got_q[i] !== ev[i]) begin n_fail++; $display("FAIL %s result%0d: got %h expected %h", name, i, got_q[i], ev[i]); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    scale = '0; zero_point = '0; size = '0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || count !== 32'd0 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h count=%0d done=%b ready=%b expected 0/0/0/0/0/1",
               in_ready, out_valid, out_data, count, done, ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    start_run(32'h0001_0000, 8'sd0, 32'd3);
    in_q = '{8'sd5, -8'sd1, 8'sd127};
    stream(100, 100, 50, 1 << 30);
    n_chk++;
    if (cyc != 6) begin n_fail++; $display("FAIL identity_latency: done at cycle %0d expected 6", cyc); end
    check_got("identity", 32'h0005_0000, 32'hFFFF_0000, 32'h007F_0000, 3);
    finish_run("identity");
  endtask

  task automatic test_zero_point();
    start_run(32'h0000_8000, -8'sd128, 32'd2);
    in_q = '{-8'sd128, 8'sd127};
    stream(70, 70, 200, 1 << 30);
    check_got("zero_point", 32'h0000_0000, 32'h007F_8000, 32'h0, 2);
    finish_run("zero_point");
  endtask

  task automatic test_overflow();
    logic [31:0] e;
`ifdef DEQUANT_SATURATE_EN
    e = 32'h8000_0000;
`else
    e = 32'h8000_00FF;
`endif
    start_run(32'h7FFF_FFFF, 8'sd127, 32'd1);
    in_q = '{-8'sd128};
    stream(100, 100, 50, 1 << 30);
    check_got("overflow", e, 32'h0, 32'h0, 1);
    finish_run("overflow");
  endtask

  task automatic test_latency();
    start_run(32'h0001_0000, 8'sd0, 32'd1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'sd3; out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL latency_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: stage %0d out_valid=%b expected 0", i, out_valid); end
    end
    @(negedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'h0003_0000) begin
      n_fail++; $display("FAIL latency_out: out_valid=%b out_data=%h expected 1/00030000", out_valid, out_data);
    end
    @(negedge clk); #1;
    n_chk++;
    if (done !== 1'b1 || count !== 32'd1) begin n_fail++; $display("FAIL latency_done: done=%b count=%0d expected 1/1", done, count); end
    @(negedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL latency_idle: done=%b ready=%b expected 0/1", done, ready); end
  endtask

  task automatic test_backpressure();
    start_run($urandom, 8'($urandom), 32'd8);
    for (int i = 0; i < 8; i++) in_q.push_back(8'($urandom));
    stream(100, 0, 10, 1 << 30);
    n_chk++;
    if (acc_cnt != DEPTH || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_stall: accepted=%0d in_ready=%b out_valid=%b expected %0d/0/1", acc_cnt, in_ready, out_valid, DEPTH);
    end
    stream(100, 100, 100, 1 << 30);
    n_chk++;
    if (got_q.size() != 8) begin n_fail++; $display("FAIL backpressure_results: got %0d expected 8", got_q.size()); end
    finish_run("backpressure");
  endtask

  task automatic test_back_to_back();
    start_run($urandom, 8'($urandom), 32'd16);
    for (int i = 0; i < 16; i++) in_q.push_back(8'($urandom));
    stream(100, 100, 100, 1 << 30);
    n_chk++;
    if (cyc != 19) begin n_fail++; $display("FAIL throughput: done at cycle %0d expected 19", cyc); end
    finish_run("back_to_back");
  endtask

  task automatic test_size_zero();
    start_run(32'h0001_0000, 8'sd0, 32'd0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'sd1;
    #1;
    n_chk++;
    if (done !== 1'b1 || in_ready !== 1'b0 || count !== 32'd0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL size_zero_done: done=%b in_ready=%b count=%0d ready=%b expected 1/0/0/0", done, in_ready, count, ready);
    end
    @(negedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || in_ready !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL size_zero_idle: done=%b in_ready=%b ready=%b expected 0/0/1", done, in_ready, ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start_run($urandom, 8'($urandom), 32'd6);
    for (int i = 0; i < 6; i++) in_q.push_back(8'($urandom));
    stream(100, 0, 20, 2);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || count !== 32'd0 || ready !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_run: out_valid=%b count=%0d ready=%b done=%b in_ready=%b expected 0/0/1/0/0",
                         out_valid, count, ready, done, in_ready);
    end
    rst_n = 1'b1;
    in_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_done: cycle %0d done=%b out_valid=%b expected 0/0", i, done, out_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      start_run($urandom, 8'($urandom), 32'(n));
      for (int i = 0; i < n; i++) in_q.push_back(8'($urandom));
      stream(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 2000, 1 << 30);
      finish_run("random");
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_zero_point();
    test_overflow();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_size_zero();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dequantize_unit.md
# dequantize_unit

Streaming int8-to-fixed-point dequantization stage that consumes the int8 tensor produced by the quantization stage and emits Q16.16 values for the float-domain post-processing ops. Each sample is computed as (q − zero_point) × scale. A run starts with a start pulse, accepts exactly `size` samples over a valid/ready input, and buffers results in a small output FIFO. It signals `done` after the last result has been consumed downstream.

## Interface

- DEPTH, 4, output FIFO depth in entries (power of two, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin run; sampled only in IDLE
- scale  in  32  signed Q16.16 multiplier; latched on accepted start
- zero_point  in  8  signed int8 zero point; latched on accepted start
- size  in  32  unsigned sample count for the run; latched on accepted start
- in_valid  in  1  input sample valid
- in_ready  out  1  input may be accepted this cycle
- in_data  in  8  signed int8 sample
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream accepts out_data
- out_data  out  32  signed Q16.16 result
- count  out  32  results emitted in the current run
- done  out  1  one-cycle pulse at run completion
- ready  out  1  block idle, start will be accepted

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: ready=1. When start=1, latch scale, zero_point and size, clear the counters, then:
  - go to DONE if size==0;
  - otherwise go to RUN.
- RUN: an input is accepted on an edge where in_valid && in_ready.
  - in_ready = (state==RUN) && (accepted < size) && (fifo_count + inflight < DEPTH). inflight counts pipeline stages holding a sample.
  - When accepted reaches size, go to DRAIN.
- DRAIN: in_ready=0. Stay until emitted == size, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. count holds its final value until the next accepted start.
- start outside IDLE is ignored.
- Pipeline stage 1: d = sign-extended in_data − sign-extended zero_point, as a 9-bit signed value (range −255..255).
- Pipeline stage 2: p = d × scale, a 41-bit signed product, already in Q16.16.
- The result is written into the FIFO. A FIFO pop occurs on out_valid && out_ready and increments count.
- A simultaneous FIFO push and pop in the same cycle keeps fifo_count unchanged.
- The credit rule guarantees the FIFO never overflows and no sample is dropped.
- Reset in any state: return to IDLE, flush the pipeline and FIFO, clear all counters, and drop the run without asserting done.

## Timing

- Reset values: in_ready=0, out_valid=0, out_data=0, count=0, done=0, ready=1.
- Latency: a sample accepted at edge E appears with out_valid=1 in the cycle after edge E+2, provided the FIFO was empty.
- Throughput: one sample per cycle while out_ready=1.
- out_data and out_valid are held stable while out_valid && !out_ready.
- done rises in the cycle after the edge that pops the last result.
- With size==0, done rises in the cycle after the start edge.
- ready=0 from the cycle after an accepted start until the cycle after done.

## Configuration

- DEQUANT_SATURATE_EN defined:
  - p > 0x7FFFFFFF is clamped to 0x7FFFFFFF;
  - p < −2^31 is clamped to 0x80000000.
- DEQUANT_SATURATE_EN undefined: out_data = p[31:0] (two's-complement wrap).

## Test plan

- Identity: scale=0x00010000, zero_point=0, size=3, inputs 5, −1, 127 → out_data 0x00050000, 0xFFFF0000, 0x007F0000; count=3; one done pulse.
- Zero point and fraction: scale=0x00008000, zero_point=−128, input −128 → 0x00000000; input 127 → 0x007F8000.
- Overflow: scale=0x7FFFFFFF, zero_point=127, input −128 → 0x80000000 with DEQUANT_SATURATE_EN defined; 0x800000FF without it.
- Backpressure: DEPTH=4, size=8, out_ready=0, in_valid=1 → in_ready drops after 4 accepts. Then release out_ready → all 8 results in order, no loss.
- size=0: pulse start → done=1 in the next cycle, in_ready never asserted, count=0.
- Reset mid-run: assert rst_n=0 after 2 of size=6 accepted → next cycle in IDLE, out_valid=0, count=0, ready=1, no done pulse.
